// File: rtl/seq_mag_cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// running compare flags carried from chunk to chunk.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } cmp_state_t;

  typedef struct packed {
    logic eq;
    logic gt;
  } cmp_flags_t;

  // Chunk counter width; a single-chunk walk still needs one bit.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_mag_cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module chunk_cmp #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  output logic             eq,
  output logic             gt
);

  assign eq = (a_chunk == b_chunk);
  assign gt = (a_chunk > b_chunk);

endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle WIDTH-bit magnitude comparator, walking MSB-first CHUNK bits per
// clock. Define SEQ_MAG_CMP_SIGNED_EN for a two's-complement compare.
module seq_mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  cmp_flags_t       flags_q, flags_d;
  logic             aeqb_q, aeqb_d;
  logic             agtb_q, agtb_d;
  logic             altb_q, altb_d;

  logic [WIDTH-1:0] a_cap, b_cap;
  logic             c_eq, c_gt;

`ifdef SEQ_MAG_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement onto an order-preserving
  // unsigned range, so the chunk walk itself stays unsigned.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
  assign a_cap = a ^ SIGN_MASK;
  assign b_cap = b ^ SIGN_MASK;
`else
  assign a_cap = a;
  assign b_cap = b;
`endif

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_chunk (a_sh_q[WIDTH-1 -: CHUNK]),
    .b_chunk (b_sh_q[WIDTH-1 -: CHUNK]),
    .eq      (c_eq),
    .gt      (c_gt)
  );

  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a_cap;
          b_sh_d  = b_cap;
          flags_d = '{eq: 1'b1, gt: 1'b0};
          cnt_d   = CW'(NCHUNK - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The first differing chunk decides; later chunks cannot override it.
        if (flags_q.eq && !c_eq) begin
          flags_d.eq = 1'b0;
          flags_d.gt = c_gt;
        end
        a_sh_d = a_sh_q << CHUNK;
        b_sh_d = b_sh_q << CHUNK;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          aeqb_d  = flags_d.eq;
          agtb_d  = ~flags_d.eq & flags_d.gt;
          altb_d  = ~flags_d.eq & ~flags_d.gt;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign aeqb  = aeqb_q;
  assign agtb  = agtb_q;
  assign altb  = altb_q;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed bench for seq_mag_cmp (WIDTH=8, CHUNK=2); expectations follow
// SEQ_MAG_CMP_SIGNED_EN when the design is built with it.
module tb_seq_mag_cmp;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  // Expected {aeqb, agtb, altb} for the vectors whose order depends on signedness.
`ifdef SEQ_MAG_CMP_SIGNED_EN
  localparam logic [2:0] EXP_C0_7F = 3'b001;
  localparam logic [2:0] EXP_80_7F = 3'b001;
  localparam logic [2:0] EXP_F0_00 = 3'b001;
`else
  localparam logic [2:0] EXP_C0_7F = 3'b010;
  localparam logic [2:0] EXP_80_7F = 3'b010;
  localparam logic [2:0] EXP_F0_00 = 3'b010;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             ready, done, aeqb, agtb, altb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mag_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .aeqb  (aeqb),
    .agtb  (agtb),
    .altb  (altb)
  );

  // Present a request so that it is sampled on the next rising edge.
  task automatic start_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count falling edges after the accepting edge until done, bounded.
  task automatic wait_done(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen   = 1'b1;
        cycles = i;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ready, done, aeqb, agtb, altb} !== 5'b10000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got rdy/done/eq/gt/lt=%b want 10000", i,
                 {ready, done, aeqb, agtb, altb});
      end
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ready, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got rdy/done=%b want 10", {ready, done});
    end
  endtask

  task automatic test_equal();
    start_cmp(8'h5A, 8'h5A);
    for (int i = 1; i <= NCHUNK + 1; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0 || done !== (i == NCHUNK + 1)) begin
        n_fail++;
        $display("FAIL equal_timing[%0d]: got rdy=%b done=%b want rdy=0 done=%b", i,
                 ready, done, (i == NCHUNK + 1));
      end
    end
    n_checks++;
    if ({aeqb, agtb, altb} !== 3'b100) begin
      n_fail++;
      $display("FAIL equal_result: got %b want 100", {aeqb, agtb, altb});
    end
    @(negedge clk);
    n_checks++;
    if ({ready, done, aeqb, agtb, altb} !== 5'b10100) begin
      n_fail++;
      $display("FAIL equal_after: got rdy/done/eq/gt/lt=%b want 10100",
               {ready, done, aeqb, agtb, altb});
    end
  endtask

  task automatic test_order();
    logic [WIDTH-1:0] va [4] = '{8'hC0, 8'h12, 8'h80, 8'hFF};
    logic [WIDTH-1:0] vb [4] = '{8'h7F, 8'h13, 8'h7F, 8'hFF};
    logic [2:0]       ve [4] = '{EXP_C0_7F, 3'b001, EXP_80_7F, 3'b100};
    int cycles;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      start_cmp(va[i], vb[i]);
      wait_done(cycles, seen);
      n_checks++;
      if (!seen || cycles != NCHUNK + 1) begin
        n_fail++;
        $display("FAIL order_latency[%0h/%0h]: got seen=%0d cycles=%0d want 1 %0d",
                 va[i], vb[i], seen, cycles, NCHUNK + 1);
      end
      n_checks++;
      if ({aeqb, agtb, altb} !== ve[i]) begin
        n_fail++;
        $display("FAIL order_result[%0h/%0h]: got %b want %b", va[i], vb[i],
                 {aeqb, agtb, altb}, ve[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cycles;
    bit seen;
    int extra_done;
    start_cmp(8'h01, 8'h02);
    for (int i = 1; i <= NCHUNK + 1; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== (i == NCHUNK + 1)) begin
        n_fail++;
        $display("FAIL busy_done[%0d]: got %b want %b", i, done, (i == NCHUNK + 1));
      end
      if (i == 1) begin
        start = 1'b1;
        a     = 8'hF0;
        b     = 8'h00;
      end
      if (i == NCHUNK) start = 1'b0;
    end
    n_checks++;
    if ({aeqb, agtb, altb} !== 3'b001) begin
      n_fail++;
      $display("FAIL busy_result: got %b want 001", {aeqb, agtb, altb});
    end
    // Request during the DONE cycle must wait for the following IDLE edge.
    start = 1'b1;
    a     = 8'hF0;
    b     = 8'h00;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_checks++;
        if (ready !== 1'b1) begin
          n_fail++;
          $display("FAIL second_wait: got ready=%b want 1", ready);
        end
      end
      if (i == 2) begin
        start = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL second_accept: got ready=%b want 0", ready);
        end
      end
      if (done === 1'b1) begin
        seen   = 1'b1;
        cycles = i;
      end
    end
    n_checks++;
    if (!seen || cycles != NCHUNK + 2) begin
      n_fail++;
      $display("FAIL second_latency: got seen=%0d cycles=%0d want 1 %0d", seen, cycles,
               NCHUNK + 2);
    end
    n_checks++;
    if ({aeqb, agtb, altb} !== EXP_F0_00) begin
      n_fail++;
      $display("FAIL second_result: got %b want %b", {aeqb, agtb, altb}, EXP_F0_00);
    end
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    n_checks++;
    if (extra_done != 0) begin
      n_fail++;
      $display("FAIL busy_extra_done: got %0d pulses want 0", extra_done);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    bit seen;
    int stray_done;
    start_cmp(8'h33, 8'h11);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ready, done, aeqb, agtb, altb} !== 5'b10000) begin
      n_fail++;
      $display("FAIL abort_state: got rdy/done/eq/gt/lt=%b want 10000",
               {ready, done, aeqb, agtb, altb});
    end
    reset = 1'b0;
    stray_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) stray_done++;
    end
    n_checks++;
    if (stray_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses want 0", stray_done);
    end
    start_cmp(8'h33, 8'h11);
    wait_done(cycles, seen);
    n_checks++;
    if (!seen || cycles != NCHUNK + 1) begin
      n_fail++;
      $display("FAIL fresh_latency: got seen=%0d cycles=%0d want 1 %0d", seen, cycles,
               NCHUNK + 1);
    end
    n_checks++;
    if ({aeqb, agtb, altb} !== 3'b010) begin
      n_fail++;
      $display("FAIL fresh_result: got %b want 010", {aeqb, agtb, altb});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_equal();
    test_order();
    test_busy_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
